// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state encoding, command bytes and frame sizing helper for spi_frame_receiver
package spi_rx_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;
  localparam logic [7:0] CMD_START  = 8'h00;
  localparam logic [7:0] CMD_RESULT = 8'hFF;
  function automatic int frame_bytes(input int num_pixels, input int pixel_w);
    return num_pixels * pixel_w / 8;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with registered-edge rise/fall pulses
// ports: clk, rst (sync, active-high), din (async in), q (synchronised level), rise/fall (one-cycle pulses)
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (rst) {s1, s2, s3} <= {3{INIT}};
    else {s1, s2, s3} <= {din, s1, s2};
  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: SPI-slave front end; decodes START/RESULT commands, unpacks image bytes into
// a valid/ready pixel stream with addresses, returns the result digit over MISO, flags overruns.
// ports: clk/rst system; SCK/SS/MOSI/MISO SPI pins; pixel_* stream; frame_start/frame_done pulses;
//        result_digit/result_valid from the core; overrun sticky flag.
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int PIXEL_W    = 4,
  parameter int NUM_PIXELS = 144,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          SCK,
  input  logic                          SS,
  input  logic                          MOSI,
  output logic                          MISO,
  output logic [PIXEL_W-1:0]            pixel_data,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel_addr,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic                          frame_start,
  output logic                          frame_done,
  input  logic [3:0]                    result_digit,
  input  logic                          result_valid,
  output logic                          overrun
);
  localparam int AW           = $clog2(NUM_PIXELS);
  localparam int PIX_PER_BYTE = 8 / PIXEL_W;
  localparam int FRAME_BYTES  = frame_bytes(NUM_PIXELS, PIXEL_W);
  localparam int BW           = $clog2(FRAME_BYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);
  localparam logic [3:0] PPB = 4'(PIX_PER_BYTE);

  if (PIXEL_W != 1 && PIXEL_W != 2 && PIXEL_W != 4 && PIXEL_W != 8) begin : g_bad_pixel_w
    $error("PIXEL_W must be 1, 2, 4 or 8");
  end
  if (NUM_PIXELS < 2 || (NUM_PIXELS * PIXEL_W) % 8 != 0) begin : g_bad_num_pixels
    $error("NUM_PIXELS*PIXEL_W must be a positive multiple of 8");
  end

  logic sck_rise, sck_fall, ss_q, mosi_q;
  logic sck_lvl_unused, ss_rise_unused, ss_fall_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.INIT(1'b0)) u_sck (.clk(clk), .rst(rst), .din(SCK), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.INIT(1'b1)) u_ss (.clk(clk), .rst(rst), .din(SS), .q(ss_q), .rise(ss_rise_unused), .fall(ss_fall_unused));
  spi_sync_edge #(.INIT(1'b0)) u_mosi (.clk(clk), .rst(rst), .din(MOSI), .q(mosi_q), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;
  logic       byte_done;

  always_ff @(posedge clk)
    if (rst || ss_q) begin
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= sck_rise && bit_cnt == 3'd7;
      if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_byte <= LSB_FIRST ? {mosi_q, rx_byte[7:1]} : {rx_byte[6:0], mosi_q};
      end
    end

  state_t          state, state_d;
  logic [7:0]      data_q, tx;
  logic [3:0]      pend;
  logic [BW-1:0]   byte_cnt;
  logic            tx_armed, xfer, busy, start_c, load_c, result_c, ovr_c, done_c;

  assign pixel_valid = pend != 4'd0;
  assign pixel_data  = data_q[PIXEL_W-1:0];
  assign MISO        = LSB_FIRST ? tx[0] : tx[7];

  // A byte arriving alongside the last pending transfer is accepted, not an overrun.
  always_comb begin
    xfer     = pixel_valid && pixel_ready;
    busy     = pixel_valid && !(pend == 4'd1 && xfer);
    state_d  = state;
    start_c  = 1'b0;
    load_c   = 1'b0;
    result_c = 1'b0;
    ovr_c    = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: if (byte_done) begin
        start_c  = rx_byte == CMD_START;
        result_c = rx_byte == CMD_RESULT;
        state_d  = start_c ? RECV : IDLE;
      end
      RECV: if (byte_done) begin
        ovr_c   = busy;
        load_c  = !busy;
        state_d = load_c && byte_cnt == LAST_BYTE ? DRAIN : RECV;
      end
      DRAIN: begin
        done_c  = !pixel_valid;
        state_d = done_c ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_armed is cleared on load so the remaining SCK fall of the RESULT byte itself
  // does not shift out bit 0 before the master's readback byte begins.
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      data_q      <= '0;
      pend        <= '0;
      byte_cnt    <= '0;
      pixel_addr  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      tx          <= '0;
      tx_armed    <= 1'b0;
    end else begin
      state       <= state_d;
      frame_start <= start_c;
      frame_done  <= done_c;
      if (load_c) begin
        data_q <= rx_byte;
        pend   <= PPB;
      end else if (xfer) begin
        data_q <= data_q >> PIXEL_W;
        pend   <= pend - 4'd1;
      end
      byte_cnt   <= start_c ? '0 : byte_cnt + BW'(load_c);
      pixel_addr <= start_c ? '0 : pixel_addr + AW'(xfer);
      overrun    <= !start_c && (overrun || ovr_c);
      if (result_c) tx <= {result_valid, 3'b000, result_digit};
      else if (sck_fall && !ss_q && tx_armed) tx <= LSB_FIRST ? {1'b0, tx[7:1]} : {tx[6:0], 1'b0};
      tx_armed <= !result_c && !ss_q && (tx_armed || sck_rise);
    end
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver: directed self-checking bench for spi_frame_receiver (default and MSB-first/8-bit builds)
module tb_spi_frame_receiver;
  logic       clk = 1'b0, rst = 1'b0;
  logic       sck = 1'b0, ss = 1'b1, mosi = 1'b0, ready = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       rvalid = 1'b0;
  logic       miso0, pv0, fs0, fd0, ovr0;
  logic [3:0] pd0;
  logic [7:0] pa0;
  logic       miso1, pv1, fs1, fd1, ovr1;
  logic [7:0] pd1;
  logic [1:0] pa1;
  int vectors = 0, miscompares = 0;
  int fs0_n = 0, fd0_n = 0, fd1_n = 0;
  logic [7:0] qa0[$], qd0[$], qa1[$], qd1[$];
  logic [7:0] got;

  always #2.5 clk = ~clk;

  spi_frame_receiver u_dut (
    .clk(clk), .rst(rst), .SCK(sck), .SS(ss), .MOSI(mosi), .MISO(miso0),
    .pixel_data(pd0), .pixel_addr(pa0), .pixel_valid(pv0), .pixel_ready(ready),
    .frame_start(fs0), .frame_done(fd0), .result_digit(digit), .result_valid(rvalid), .overrun(ovr0)
  );

  spi_frame_receiver #(.PIXEL_W(8), .NUM_PIXELS(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .SCK(sck), .SS(ss), .MOSI(mosi), .MISO(miso1),
    .pixel_data(pd1), .pixel_addr(pa1), .pixel_valid(pv1), .pixel_ready(ready),
    .frame_start(fs1), .frame_done(fd1), .result_digit(digit), .result_valid(rvalid), .overrun(ovr1)
  );

  always @(negedge clk) if (!rst) begin
    if (fs0) fs0_n++;
    if (fd0) fd0_n++;
    if (fd1) fd1_n++;
    if (pv0 && ready) begin qa0.push_back(pa0); qd0.push_back(8'(pd0)); end
    if (pv1 && ready) begin qa1.push_back(8'(pa1)); qd1.push_back(pd1); end
  end

  task automatic check(input string tag, input logic [31:0] seen, input logic [31:0] want);
    vectors++;
    if (seen !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, seen, want);
    end
  endtask

  task automatic spi(input logic [7:0] b, input int nbits, input bit msb, output logic [7:0] rd);
    rd = '0;
    @(negedge clk);
    ss = 1'b0;
    #40;
    for (int i = 0; i < nbits; i++) begin
      mosi = msb ? b[7-i] : b[i];
      #20;
      rd[msb ? 7-i : i] = miso0;
      sck = 1'b1;
      #40;
      sck = 1'b0;
      #20;
    end
    #20;
    ss = 1'b1;
    #60;
  endtask

  task automatic send(input logic [7:0] b, input bit msb);
    logic [7:0] d;
    spi(b, 8, msb, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fs0_n = 0; fd0_n = 0; fd1_n = 0;
    qa0.delete(); qd0.delete(); qa1.delete(); qd1.delete();
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(pv0), 0);
    check("rst_data", 32'(pd0), 0);
    check("rst_addr", 32'(pa0), 0);
    check("rst_fstart", 32'(fs0), 0);
    check("rst_fdone", 32'(fd0), 0);
    check("rst_overrun", 32'(ovr0), 0);
    check("rst_miso", 32'(miso0), 0);

    send(8'h00, 1'b0);
    for (int n = 0; n < 72; n++) send({4'(2*n+1), 4'(2*n)}, 1'b0);
    repeat (10) @(negedge clk);
    check("t1_xfers", 32'(qa0.size()), 144);
    for (int i = 0; i < 144; i++) begin
      check($sformatf("t1_addr%0d", i), 32'(qa0[i]), 32'(i));
      check($sformatf("t1_data%0d", i), 32'(qd0[i]), 32'(i % 16));
    end
    check("t1_fstart_n", 32'(fs0_n), 1);
    check("t1_fdone_n", 32'(fd0_n), 1);
    check("t1_overrun", 32'(ovr0), 0);

    do_reset();
    send(8'h00, 1'b1);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    check("t2_xfers", 32'(qa1.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_addr%0d", i), 32'(qa1[i]), 32'(i));
    check("t2_data0", 32'(qd1[0]), 32'h A5);
    check("t2_data1", 32'(qd1[1]), 32'h3C);
    check("t2_data2", 32'(qd1[2]), 32'hFF);
    check("t2_data3", 32'(qd1[3]), 32'h00);
    check("t2_fdone_n", 32'(fd1_n), 1);

    do_reset();
    rvalid = 1'b1;
    digit  = 4'd7;
    send(8'hFF, 1'b0);
    check("t3_miso_first", 32'(miso0), 1);
    spi(8'h5A, 8, 1'b0, got);
    check("t3_readback", 32'(got), 32'h87);
    check("t3_miso_idle", 32'(miso0), 0);
    rvalid = 1'b0;

    do_reset();
    ready = 1'b0;
    send(8'h00, 1'b0);
    send(8'h21, 1'b0);
    send(8'h43, 1'b0);
    @(negedge clk);
    check("t4_overrun", 32'(ovr0), 1);
    check("t4_valid", 32'(pv0), 1);
    check("t4_data", 32'(pd0), 1);
    check("t4_addr", 32'(pa0), 0);
    ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_xfers", 32'(qa0.size()), 2);
    check("t4_addr0", 32'(qa0[0]), 0);
    check("t4_data0", 32'(qd0[0]), 1);
    check("t4_addr1", 32'(qa0[1]), 1);
    check("t4_data1", 32'(qd0[1]), 2);
    check("t4_drained", 32'(pv0), 0);
    for (int n = 0; n < 71; n++) send(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    check("t4_fdone_n", 32'(fd0_n), 1);
    check("t4_sticky", 32'(ovr0), 1);
    send(8'h00, 1'b0);
    @(negedge clk);
    check("t4_fstart_n", 32'(fs0_n), 2);
    check("t4_cleared", 32'(ovr0), 0);

    do_reset();
    send(8'h00, 1'b0);
    send(8'h10, 1'b0);
    send(8'h32, 1'b0);
    send(8'h54, 1'b0);
    spi(8'hFF, 5, 1'b0, got);
    repeat (10) @(negedge clk);
    check("t5_abort_xfers", 32'(qa0.size()), 6);
    check("t5_abort_valid", 32'(pv0), 0);
    send(8'h76, 1'b0);
    @(negedge clk);
    check("t5_resume_xfers", 32'(qa0.size()), 8);
    check("t5_resume_addr", 32'(qa0[6]), 6);
    check("t5_resume_d6", 32'(qd0[6]), 6);
    check("t5_resume_d7", 32'(qd0[7]), 7);
    ready = 1'b0;
    send(8'h98, 1'b0);
    send(8'hBA, 1'b0);
    @(negedge clk);
    check("t5_pre_ovr", 32'(ovr0), 1);
    check("t5_pre_valid", 32'(pv0), 1);
    check("t5_pre_data", 32'(pd0), 8);
    check("t5_pre_addr", 32'(pa0), 8);
    do_reset();
    @(negedge clk);
    check("t5_rst_valid", 32'(pv0), 0);
    check("t5_rst_data", 32'(pd0), 0);
    check("t5_rst_addr", 32'(pa0), 0);
    check("t5_rst_ovr", 32'(ovr0), 0);
    check("t5_rst_miso", 32'(miso0), 0);
    check("t5_rst_fs", 32'(fs0), 0);
    check("t5_rst_fd", 32'(fd0), 0);
    ready = 1'b1;
    send(8'h00, 1'b0);
    send(8'h21, 1'b0);
    @(negedge clk);
    check("t5_new_fs", 32'(fs0_n), 1);
    check("t5_new_xfers", 32'(qa0.size()), 2);
    check("t5_new_addr0", 32'(qa0[0]), 0);
    check("t5_new_d0", 32'(qd0[0]), 1);
    check("t5_new_d1", 32'(qd0[1]), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Parametrised SPI-slave front end for the digit recogniser: it sits between the external SPI pins (SCK, SS, MOSI, MISO) and the inference core. It decodes per-byte SPI transactions into commands, unpacks image bytes into pixels, and streams them out over a valid/ready handshake with running addresses. It also returns the recognised digit over MISO on request. It generalises the fixed 4-bit, 144-pixel, LSB-first receiver to any pixel width, frame size and bit order, and adds result readback and overrun detection.

## Interface
- PIXEL_W, 4, bits per pixel; one of 1, 2, 4, 8
- NUM_PIXELS, 144, pixels per frame; NUM_PIXELS*PIXEL_W must be a multiple of 8
- LSB_FIRST, 1, serial bit order for both MOSI and MISO; 1 = bit 0 first
- clk  in  1  system clock; the only clock
- rst  in  1  reset; synchronous, active-high
- SCK  in  1  SPI clock, asynchronous to clk; mode 0
- SS  in  1  slave select, active-low, asynchronous; one byte per SS-low window
- MOSI  in  1  serial data in, asynchronous
- MISO  out  1  serial data out
- pixel_data  out  PIXEL_W  current pixel
- pixel_addr  out  $clog2(NUM_PIXELS)  index of pixel_data within the frame
- pixel_valid  out  1  pixel_data and pixel_addr are valid
- pixel_ready  in  1  downstream accepts; transfer occurs when valid && ready
- frame_start  out  1  one-cycle pulse when a START command is decoded
- frame_done  out  1  one-cycle pulse when pixel NUM_PIXELS-1 has been transferred
- result_digit  in  4  digit from the core
- result_valid  in  1  result_digit is meaningful
- overrun  out  1  sticky: a byte arrived while the unpack register was still busy

## Operation
- **Synchronisers.** SCK, SS and MOSI each pass through a 2-flop synchroniser. SCK rise and fall are detected from the synchronised signal.
- **Receive.** On each synchronised SCK rise with SS low, shift in MOSI. With LSB_FIRST=1 the first bit lands in bit 0; with LSB_FIRST=0 it lands in bit 7.
  - The 8th bit produces a one-cycle internal byte_done.
  - SS high clears the bit counter and discards partial bits; FSM state is unchanged.
- **FSM states:** IDLE, RECV, DRAIN.
  - IDLE: byte 0x00 (START) pulses frame_start, clears pixel count and overrun, then goes to RECV. Byte 0xFF (RESULT) loads the transmit register with {result_valid, 3'b000, result_digit} and stays in IDLE. Any other byte is ignored.
  - RECV: every byte is image data, including 0x00 and 0xFF. The byte is loaded into the unpack register.
    - Pixels are emitted low-bits-first: pixel k of a byte is bits [k*PIXEL_W +: PIXEL_W]. This gives 8/PIXEL_W pixels per byte.
    - After loading the last frame byte, go to DRAIN.
  - DRAIN: wait until the unpack register is empty, pulse frame_done, then return to IDLE.
- **Overrun.** If byte_done occurs while the unpack register still holds untransferred pixels:
  - the new byte is dropped;
  - overrun is set;
  - byte and pixel counts do not advance.
- **pixel_addr** increments on every transfer. It starts at 0 at START and never wraps inside a frame. pixel_valid stays high until the pixel is accepted.
- **Transmit.** The transmit register drives MISO with its first bit immediately after loading, then shifts on each synchronised SCK fall while SS is low. After 8 falls MISO holds 0.
- **Reset:** pixel_valid=0, pixel_data=0, pixel_addr=0, frame_start=0, frame_done=0, overrun=0, MISO=0, FSM=IDLE. Synchroniser flops reset to SCK=0, SS=1, MOSI=0. A reset mid-frame abandons the frame.

## Timing
- SCK high and low phases must each be at least 4 clk periods. The system runs at 5 ns clk with an 83 ns SCK period.
- Byte latency: byte_done is 3 clk after the SCK rise carrying the 8th bit (2 sync + 1 edge detect).
- pixel_valid rises 1 clk after byte_done. With pixel_ready held high, one pixel transfers per clk, so a byte drains in 8/PIXEL_W clk.
- frame_start is asserted 1 clk after byte_done of the START byte.
- frame_done is asserted 1 clk after the final transfer.
- MISO lags the SCK fall by 3 clk, which is well inside half an SCK period.
- Simultaneous byte_done and the final pixel transfer of the previous byte: not an overrun. The new byte loads in the same cycle.

## Structure
- Package spi_rx_pkg holds:
  - the state enum (IDLE, RECV, DRAIN);
  - CMD_START = 8'h00 and CMD_RESULT = 8'hFF;
  - localparams PIX_PER_BYTE = 8/PIXEL_W and FRAME_BYTES = NUM_PIXELS*PIXEL_W/8, computed in the module from the package helper function.
- Sub-module spi_sync_edge: a 2-flop synchroniser with rise/fall pulse outputs. It is instantiated for SCK; the SS and MOSI instances leave the edge outputs unused.
- Elaboration-time assertions check the legality of PIXEL_W and NUM_PIXELS.

## Test plan
- **Default parameters, pixel_ready=1.** Send START, then 72 bytes where byte n = {4'(2n+1), 4'(2n)} mod 16. Expect 144 transfers with pixel_addr 0..143 and pixel_data = addr mod 16, one frame_start, one frame_done, overrun=0.
- **LSB_FIRST=0, PIXEL_W=8, NUM_PIXELS=4.** Send START, then 0xA5, 0x3C, 0xFF, 0x00 MSB-first. Expect pixels A5, 3C, FF, 00 and frame_done.
- **Result readback.** With result_valid=1 and result_digit=7, send 0xFF and then one dummy byte. Expect MISO to carry 0x87 LSB-first.
- **Backpressure.** Hold pixel_ready=0 and send 2 data bytes. Expect overrun=1, only the first byte's pixels pending, and pixel_addr 0 and 1 once released. A following START clears overrun.
- **SS abort and reset.** Raise SS after 5 bits mid-frame. Expect no byte_done and an unchanged pixel count. Assert rst mid-frame: all outputs return to their reset values and a new START is accepted.
